// File: rtl/hi_15_xfer_sequencer.sv
// ISO15693 reader transaction sequencer: steers the datapath minor_mode through TX, guard, listen and receive.
// Optional JAM state is built only when HI15_SEQ_JAM_EN is defined.
module hi_15_xfer_sequencer #(
   parameter int GUARD_W = 12,
   parameter int WIN_W   = 16
) (
   input  logic               ck_1356meg_i,
   input  logic               reset_i,
   input  logic               frame_tick_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic               sniff_i,
   input  logic               full_mod_i,
   input  logic               tx_last_i,
   input  logic [GUARD_W-1:0] guard_frames_i,
   input  logic [WIN_W-1:0]   window_frames_i,
   input  logic [7:0]         idle_frames_i,
   input  logic               rx_active_i,
`ifdef HI15_SEQ_JAM_EN
   input  logic               jam_req_i,
`endif
   output logic [3:0]         minor_mode_o,
   output logic               rx_valid_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               timeout_o,
   output logic               got_response_o
);

   localparam logic [3:0] MODE_RX_AMP     = 4'd1;
   localparam logic [3:0] MODE_SEND_FULL  = 4'd3;
   localparam logic [3:0] MODE_SEND_SHAL  = 4'd4;
   localparam logic [3:0] MODE_SNIFF_AMP  = 4'd6;
`ifdef HI15_SEQ_JAM_EN
   localparam logic [3:0] MODE_SEND_JAM   = 4'd8;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_TX     = 3'd1,
      S_GUARD  = 3'd2,
      S_LISTEN = 3'd3,
      S_RECV   = 3'd4
`ifdef HI15_SEQ_JAM_EN
      ,S_JAM   = 3'd5
`endif
   } state_t;

   state_t             state_q, state_d;
   logic               sniff_q, sniff_d;
   logic               full_mod_q, full_mod_d;
   logic [GUARD_W-1:0] guard_cfg_q, guard_cfg_d;
   logic [WIN_W-1:0]   win_cfg_q, win_cfg_d;
   logic [7:0]         idle_cfg_q, idle_cfg_d;
   logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
   logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
   logic [7:0]         quiet_cnt_q, quiet_cnt_d;
   logic               got_q, got_d;
   logic               done_q, done_d;
   logic               timeout_q, timeout_d;
   logic [3:0]         mode_q, mode_d;
   logic               busy_q, busy_d;
   logic               rx_valid_q, rx_valid_d;
   logic [7:0]         quiet_load;

   // An idle_frames of 0 would end RECV without ever waiting, so treat it as 1.
   assign quiet_load = (idle_cfg_q == 8'd0) ? 8'd1 : idle_cfg_q;

   always_comb begin
      state_d     = state_q;
      sniff_d     = sniff_q;
      full_mod_d  = full_mod_q;
      guard_cfg_d = guard_cfg_q;
      win_cfg_d   = win_cfg_q;
      idle_cfg_d  = idle_cfg_q;
      guard_cnt_d = guard_cnt_q;
      win_cnt_d   = win_cnt_q;
      quiet_cnt_d = quiet_cnt_q;
      got_d       = got_q;
      done_d      = 1'b0;
      timeout_d   = 1'b0;

      if (abort_i) begin
         state_d     = S_IDLE;
         guard_cnt_d = '0;
         win_cnt_d   = '0;
         quiet_cnt_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
`ifdef HI15_SEQ_JAM_EN
               if (jam_req_i) begin
                  state_d = S_JAM;
               end else
`endif
               if (start_i) begin
                  sniff_d     = sniff_i;
                  full_mod_d  = full_mod_i;
                  guard_cfg_d = guard_frames_i;
                  win_cfg_d   = window_frames_i;
                  idle_cfg_d  = idle_frames_i;
                  got_d       = 1'b0;
                  if (sniff_i) begin
                     state_d   = S_LISTEN;
                     win_cnt_d = window_frames_i;
                  end else begin
                     state_d = S_TX;
                  end
               end
            end
            S_TX: begin
               if (tx_last_i) begin
                  if (guard_cfg_q == '0) begin
                     state_d   = S_LISTEN;
                     win_cnt_d = win_cfg_q;
                  end else begin
                     state_d     = S_GUARD;
                     guard_cnt_d = guard_cfg_q;
                  end
               end
            end
            S_GUARD: begin
               if (frame_tick_i) begin
                  guard_cnt_d = (guard_cnt_q == '0) ? '0 : guard_cnt_q - 1'b1;
                  if (guard_cnt_d == '0) begin
                     state_d   = S_LISTEN;
                     win_cnt_d = win_cfg_q;
                  end
               end
            end
            S_LISTEN: begin
               // Activity is checked before the window so a coincident expiry still receives.
               if (frame_tick_i) begin
                  if (rx_active_i) begin
                     state_d     = S_RECV;
                     got_d       = 1'b1;
                     quiet_cnt_d = quiet_load;
                  end else if (win_cfg_q != '0) begin
                     win_cnt_d = (win_cnt_q == '0) ? '0 : win_cnt_q - 1'b1;
                     if (win_cnt_d == '0) begin
                        state_d   = S_IDLE;
                        done_d    = 1'b1;
                        timeout_d = 1'b1;
                     end
                  end
               end
            end
            S_RECV: begin
               if (frame_tick_i) begin
                  if (rx_active_i) begin
                     quiet_cnt_d = quiet_load;
                  end else begin
                     quiet_cnt_d = (quiet_cnt_q == 8'd0) ? 8'd0 : quiet_cnt_q - 1'b1;
                     if (quiet_cnt_d == 8'd0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
`ifdef HI15_SEQ_JAM_EN
            S_JAM: begin
               if (!jam_req_i) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they move on the same edge as the state.
   always_comb begin
      mode_d     = MODE_RX_AMP;
      busy_d     = (state_d != S_IDLE);
      rx_valid_d = (state_d == S_LISTEN) || (state_d == S_RECV);
      case (state_d)
         S_TX:     mode_d = full_mod_d ? MODE_SEND_FULL : MODE_SEND_SHAL;
         S_LISTEN,
         S_RECV:   mode_d = sniff_d ? MODE_SNIFF_AMP : MODE_RX_AMP;
`ifdef HI15_SEQ_JAM_EN
         S_JAM:    mode_d = MODE_SEND_JAM;
`endif
         default:  mode_d = MODE_RX_AMP;
      endcase
   end

   always_ff @(negedge ck_1356meg_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         sniff_q     <= 1'b0;
         full_mod_q  <= 1'b0;
         guard_cfg_q <= '0;
         win_cfg_q   <= '0;
         idle_cfg_q  <= '0;
         guard_cnt_q <= '0;
         win_cnt_q   <= '0;
         quiet_cnt_q <= '0;
         got_q       <= 1'b0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         mode_q      <= MODE_RX_AMP;
         busy_q      <= 1'b0;
         rx_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sniff_q     <= sniff_d;
         full_mod_q  <= full_mod_d;
         guard_cfg_q <= guard_cfg_d;
         win_cfg_q   <= win_cfg_d;
         idle_cfg_q  <= idle_cfg_d;
         guard_cnt_q <= guard_cnt_d;
         win_cnt_q   <= win_cnt_d;
         quiet_cnt_q <= quiet_cnt_d;
         got_q       <= got_d;
         done_q      <= done_d;
         timeout_q   <= timeout_d;
         mode_q      <= mode_d;
         busy_q      <= busy_d;
         rx_valid_q  <= rx_valid_d;
      end
   end

   assign minor_mode_o   = mode_q;
   assign busy_o         = busy_q;
   assign rx_valid_o     = rx_valid_q;
   assign done_o         = done_q;
   assign timeout_o      = timeout_q;
   assign got_response_o = got_q;

endmodule

// File: doc/hi_15_xfer_sequencer.md
# hi_15_xfer_sequencer

Transaction sequencer for the ISO15693 reader front end. It drives the reader datapath's `minor_mode` through a complete exchange: modulate (TX), guard, listen and receive. It produces `rx_valid`, `done`, `timeout` and `got_response` qualifiers for the ARM side. It sits between the ARM command/config registers and the `hi_15_reader` datapath, and runs on that datapath's 64-sample correlation frame tick.

## Interface
Parameters:
- `GUARD_W`, 12: width of the guard-time frame counter.
- `WIN_W`, 16: width of the listen-window frame counter.

Ports:
- `ck_1356meg`, in, 1: 13.56 MHz clock. All logic runs on the falling edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `frame_tick`, in, 1: one-cycle pulse per 64-sample correlation frame.
- `start`, in, 1: begin a transaction. Sampled only in IDLE.
- `abort`, in, 1: return to IDLE from any state.
- `sniff`, in, 1: selects a sniff transaction. Latched at `start`.
- `full_mod`, in, 1: selects full modulation (1) or shallow modulation (0) for TX. Latched at `start`.
- `tx_last`, in, 1: pulse that ends the TX phase.
- `guard_frames`, in, `GUARD_W`: guard time in frames. Latched at `start`.
- `window_frames`, in, `WIN_W`: listen window in frames. 0 means unlimited. Latched at `start`.
- `idle_frames`, in, 8: number of quiet frames that end RECV. 0 is treated as 1. Latched at `start`.
- `rx_active`, in, 1: tag activity from the datapath (amplitude above threshold, or fsk≠0).
- `jam_req`, in, 1: jam request. Exists only with `HI15_SEQ_JAM_EN`.
- `minor_mode`, out, 4: `FPGA_HF_READER_MODE_*` code driven to the datapath.
- `rx_valid`, out, 1: ARM may accept receive data.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at the end of a transaction.
- `timeout`, out, 1: one-cycle pulse coincident with `done` when the window expired.
- `got_response`, out, 1: sticky. Set on entry to RECV, cleared by `start`.

## Operation
States are IDLE, TX, GUARD, LISTEN, RECV, plus JAM when the macro is defined.

`minor_mode` per state:
- IDLE: RECEIVE_AMPLITUDE (field on).
- TX: SEND_FULL_MOD or SEND_SHALLOW_MOD, per the latched `full_mod`.
- GUARD: RECEIVE_AMPLITUDE.
- LISTEN and RECV: RECEIVE_AMPLITUDE, or SNIFF_AMPLITUDE if the latched `sniff` is 1.
- JAM: SEND_JAM.

Transitions:
- IDLE: `start` with `sniff`=0 goes to TX. `start` with `sniff`=1 goes to LISTEN, skipping TX and GUARD.
- TX: `tx_last` goes to GUARD and loads the guard counter with `guard_frames`. If `guard_frames`=0, go directly to LISTEN.
- GUARD: the counter decrements on each `frame_tick`. When it reaches 0, go to LISTEN and load the window counter.
- LISTEN: on a `frame_tick` where `rx_active`=1, go to RECV, set `got_response` and load the quiet counter with `idle_frames`. Otherwise, each `frame_tick` decrements the window counter (when nonzero window). The window counter reaching 0 pulses `done` and `timeout`, then goes to IDLE.
- RECV: on each `frame_tick`, `rx_active`=1 reloads the quiet counter and `rx_active`=0 decrements it. Reaching 0 pulses `done` (with `timeout`=0) and goes to IDLE. RECV has no window limit.

Qualifiers:
- `rx_valid`=1 only in LISTEN and RECV.

Event rules:
- `abort` takes priority over every other event. The next state is IDLE and no `done` pulse is produced.
- `start` while `busy` is ignored.
- `tx_last` outside TX is ignored.
- When `frame_tick` and `rx_active` arrive on the same cycle as window expiry, activity wins: the block goes to RECV and no timeout is produced.

Arithmetic:
- Counters saturate at 0 and never wrap.
- Configuration inputs are latched at `start`. Changing them mid-transaction has no effect.

## Timing
Reset values:
- State IDLE.
- `minor_mode` = RECEIVE_AMPLITUDE.
- `busy`, `rx_valid`, `done`, `timeout`, `got_response` = 0.
- All counters 0.

Latency:
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- `start` sampled at edge N puts the TX mode on `minor_mode` after edge N.
- The GUARD→LISTEN transition occurs on the `frame_tick` edge that brings the counter to 0. The guard duration is therefore exactly `guard_frames` ticks after the first tick seen in GUARD.
- `done` and `timeout` are high for exactly one cycle, on the edge that enters IDLE.
- When `reset` is asserted mid-transaction, outputs take their reset values immediately (asynchronously).

## Configuration
- `HI15_SEQ_JAM_EN` defined:
  - The `jam_req` port exists.
  - In IDLE, `jam_req`=1 enters JAM with priority over `start`.
  - JAM holds SEND_JAM with `busy`=1 and exits to IDLE the cycle after `jam_req`=0. No `done` pulse is produced.
  - `abort` also exits JAM.
- `HI15_SEQ_JAM_EN` undefined: no `jam_req` port, no JAM state, and SEND_JAM is never driven.

## Test plan
- Reset mid-TX → `minor_mode`=RECEIVE_AMPLITUDE, `busy`=0 immediately. Release reset, then `start` with `full_mod`=1 → SEND_FULL_MOD on the next edge.
- TX, then `tx_last`, `guard_frames`=3 → LISTEN entered on the 3rd `frame_tick`. `rx_valid` rises on the same edge.
- LISTEN with `window_frames`=5 and no activity → after the 5th tick, `done`=`timeout`=1 for one cycle, then IDLE, `got_response`=0.
- `rx_active` high on 2 ticks, then low, `idle_frames`=4 → RECV, `got_response`=1. `done` (with `timeout`=0) on the 4th quiet tick.
- `abort` on the same cycle as `tx_last`, and `start` while busy → IDLE with no `done`. The ignored `start` leaves the transaction untouched.
- With `HI15_SEQ_JAM_EN`, `jam_req` and `start` together in IDLE → SEND_JAM. Drop `jam_req` → IDLE one cycle later, no `done`.
